// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR draw block: FSM encoding, tap masks, seed derivation.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } draw_state_t;

  // Fibonacci feedback taps for maximal-length sequences, bit n-1 set for tap n.
  function automatic logic [15:0] tap_mask(input int width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  // Per-channel seed: base rotated left by the channel index within width bits.
  // A zero result would lock the register up, so it becomes 1 instead.
  function automatic logic [15:0] derive_seed(input logic [15:0] base, input int idx,
                                              input int width);
    logic [15:0] wmask;
    logic [15:0] b;
    logic [15:0] rot;
    int          r;
    wmask = 16'hFFFF >> (16 - width);
    b     = base & wmask;
    r     = idx % width;
    rot   = ((b << r) | (b >> (width - r))) & wmask;
    if (rot == 16'd0) begin
      rot = 16'd1;
    end
    return rot;
  endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One Fibonacci LFSR channel with derived-seed load and an all-zero lockup guard.
// Latency: state updates on the edge after enable or seed_load.
// Backpressure: none; seed_load overrides enable, enable=0 holds the register.
module lfsr_chan
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter int               CH_IDX       = 0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS     = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] RST_SEED = WIDTH'(derive_seed(16'(DEFAULT_SEED), CH_IDX, WIDTH));

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_val;

  // Derived load value and next shift value; an all-zero register is forced to 1.
  always_comb begin
    load_val = WIDTH'(derive_seed(16'(seed), CH_IDX, WIDTH));
    step_val = {state[WIDTH-2:0], ^(state & TAPS)};
    if (state == '0) begin
      step_val = WIDTH'(1);
    end
  end

  // Shift register: reset seed, then load strobe, then enabled step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_SEED;
    end else if (seed_load) begin
      state <= load_val;
    end else if (enable) begin
      state <= step_val;
    end
  end

endmodule

// File: rtl/lfsr_draw.sv
// Multi-channel LFSR symbol draw: rejection-samples each channel into 0..RANGE-1.
// Latency: at least 2 cycles from accepted draw_req to draw_valid; more while rejecting.
// Backpressure: draw_valid/draw_value held in HOLD until draw_ack; draw_req taken only when draw_ready.
module lfsr_draw
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter int               CHANNELS     = 3,
  parameter int               RANGE        = 10,
  parameter int               MAX_TRIES    = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  localparam int              SYM_W        = $clog2(RANGE)
) (
  input  logic                      clk,
  input  logic                      reset,      // asynchronous, active-low
  input  logic                      enable,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed,
  input  logic                      draw_req,
  output logic                      draw_ready,
  output logic                      draw_valid,
  input  logic                      draw_ack,
  output logic [CHANNELS*SYM_W-1:0] draw_value,
  output logic                      draw_fallback,
  output logic [CHANNELS*WIDTH-1:0] lfsr_state
);

  // One extra bit so RANGE == 2**SYM_W still compares correctly.
  localparam logic [SYM_W:0] RANGE_X  = (SYM_W+1)'(RANGE);
  localparam logic [7:0]     LAST_TRY = 8'(MAX_TRIES - 1);

  draw_state_t               state_q, state_d;
  logic [CHANNELS-1:0]       acc_q, acc_d;
  logic [CHANNELS*SYM_W-1:0] val_q, val_d;
  logic                      fb_q, fb_d;
  logic [7:0]                try_q, try_d;
  logic [SYM_W-1:0]          cand;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    lfsr_chan #(
      .WIDTH        (WIDTH),
      .CH_IDX       (i),
      .DEFAULT_SEED (DEFAULT_SEED)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .seed_load (seed_load),
      .seed      (seed),
      .state     (lfsr_state[i*WIDTH +: WIDTH])
    );
  end

  // Next-state: start a draw, evaluate pending channels each DRAW cycle, release on ack.
  // The try on which try_q equals MAX_TRIES-1 is the last one: anything still
  // out of range then folds down by RANGE and flags the fallback.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    val_d   = val_q;
    fb_d    = fb_q;
    try_d   = try_q;
    cand    = '0;
    case (state_q)
      IDLE: begin
        if (draw_req) begin
          state_d = DRAW;
          acc_d   = '0;
          try_d   = '0;
          fb_d    = 1'b0;
        end
      end
      DRAW: begin
        if (&acc_q) begin
          state_d = HOLD;
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (!acc_q[i]) begin
              cand = lfsr_state[i*WIDTH +: SYM_W];
              if ({1'b0, cand} < RANGE_X) begin
                val_d[i*SYM_W +: SYM_W] = cand;
                acc_d[i]                = 1'b1;
              end else if (try_q == LAST_TRY) begin
                val_d[i*SYM_W +: SYM_W] = SYM_W'({1'b0, cand} - RANGE_X);
                acc_d[i]                = 1'b1;
                fb_d                    = 1'b1;
              end
            end
          end
          // Frozen LFSRs re-present the same candidates, so they do not count as a try.
          if (enable) begin
            try_d = try_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (draw_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Draw control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      val_q   <= '0;
      fb_q    <= 1'b0;
      try_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      fb_q    <= fb_d;
      try_q   <= try_d;
    end
  end

  assign draw_ready    = (state_q == IDLE);
  assign draw_valid    = (state_q == HOLD);
  assign draw_fallback = draw_valid & fb_q;
  assign draw_value    = val_q;

endmodule

// File: tb/tb_lfsr_draw.sv
// Directed bench for lfsr_draw: default instance plus a 1-channel, MAX_TRIES=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_lfsr_draw;

  logic        clk = 1'b0;
  logic        reset;

  logic        enable, seed_load, draw_req, draw_ack;
  logic [9:0]  seed;
  logic        draw_ready, draw_valid, draw_fallback;
  logic [11:0] draw_value;
  logic [29:0] lfsr_state;

  logic        enable_1, seed_load_1, draw_req_1, draw_ack_1;
  logic [9:0]  seed_1;
  logic        draw_ready_1, draw_valid_1, draw_fallback_1;
  logic [3:0]  draw_value_1;
  logic [9:0]  lfsr_state_1;

  int errors = 0;
  int checks = 0;
  int steps;
  int zeros;
  int vpulse;

  always #5 clk = ~clk;

  lfsr_draw u_dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .seed_load     (seed_load),
    .seed          (seed),
    .draw_req      (draw_req),
    .draw_ready    (draw_ready),
    .draw_valid    (draw_valid),
    .draw_ack      (draw_ack),
    .draw_value    (draw_value),
    .draw_fallback (draw_fallback),
    .lfsr_state    (lfsr_state)
  );

  lfsr_draw #(
    .WIDTH        (10),
    .CHANNELS     (1),
    .RANGE        (10),
    .MAX_TRIES    (1),
    .DEFAULT_SEED (10'd1)
  ) u_one (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable_1),
    .seed_load     (seed_load_1),
    .seed          (seed_1),
    .draw_req      (draw_req_1),
    .draw_ready    (draw_ready_1),
    .draw_valid    (draw_valid_1),
    .draw_ack      (draw_ack_1),
    .draw_value    (draw_value_1),
    .draw_fallback (draw_fallback_1),
    .lfsr_state    (lfsr_state_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 0; seed_load = 0; draw_req = 0; draw_ack = 0; seed = '0;
    enable_1 = 0; seed_load_1 = 0; draw_req_1 = 0; draw_ack_1 = 0; seed_1 = '0;
    #2 reset = 1'b0;
    #2;
    // Reset state: derived seeds 001, 002, 004
    check("rst_ready",   32'(draw_ready),    32'd1);
    check("rst_valid",   32'(draw_valid),    32'd0);
    check("rst_fb",      32'(draw_fallback), 32'd0);
    check("rst_value",   32'(draw_value),    32'd0);
    check("rst_state",   32'(lfsr_state),    32'({10'h004, 10'h002, 10'h001}));
    check("rst_state_1", 32'(lfsr_state_1),  32'h001);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Sequence and period of channel 0
    seed = 10'h001; seed_load = 1; enable = 1;
    tick();
    seed_load = 0;
    check("load_001", 32'(lfsr_state[9:0]), 32'h001);
    tick();
    check("step1", 32'(lfsr_state[9:0]), 32'h002);
    tick();
    check("step2", 32'(lfsr_state[9:0]), 32'h004);
    steps = 2;
    while (lfsr_state[9:0] !== 10'h001 && steps < 2000) begin
      tick();
      steps++;
    end
    check("period", 32'(steps), 32'd1023);

    // Zero seed is replaced by 1 and the registers never reach zero
    seed = 10'h000; seed_load = 1;
    tick();
    seed_load = 0;
    check("seed0", 32'(lfsr_state), 32'({10'h001, 10'h001, 10'h001}));
    zeros = 0;
    repeat (2000) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        if (lfsr_state[c*10 +: 10] == 10'h000) zeros++;
      end
    end
    check("no_zero", 32'(zeros), 32'd0);
    enable = 0;

    // Default-instance draw on frozen seeds 001/002/004 -> symbols 1/2/4
    seed = 10'h001; seed_load = 1;
    tick();
    seed_load = 0;
    draw_req = 1;
    tick();
    draw_req = 0;
    check("draw_busy",   32'(draw_ready), 32'd0);
    check("draw_lat1",   32'(draw_valid), 32'd0);
    tick();
    check("draw_lat2",   32'(draw_valid), 32'd0);
    tick();
    check("draw_valid",  32'(draw_valid),    32'd1);
    check("draw_value",  32'(draw_value),    32'h421);
    check("draw_nofb",   32'(draw_fallback), 32'd0);
    for (int k = 0; k < 5; k++) begin
      draw_req = (k == 2);
      tick();
      check("hold_valid", 32'(draw_valid), 32'd1);
      check("hold_value", 32'(draw_value), 32'h421);
    end
    draw_req = 0;
    check("hold_noready", 32'(draw_ready), 32'd0);
    draw_ack = 1;
    tick();
    draw_ack = 0;
    check("ack_ready", 32'(draw_ready), 32'd1);
    check("ack_valid", 32'(draw_valid), 32'd0);
    tick();
    check("idle_stays", 32'(draw_ready), 32'd1);

    // Single channel, nibble 3 -> symbol 3, no fallback
    seed_1 = 10'h003; seed_load_1 = 1;
    tick();
    seed_load_1 = 0;
    draw_req_1 = 1;
    tick();
    draw_req_1 = 0;
    check("one_lat1", 32'(draw_valid_1), 32'd0);
    tick();
    check("one_lat2", 32'(draw_valid_1), 32'd0);
    tick();
    check("one_valid", 32'(draw_valid_1),    32'd1);
    check("one_value", 32'(draw_value_1),    32'd3);
    check("one_nofb",  32'(draw_fallback_1), 32'd0);
    draw_ack_1 = 1;
    tick();
    draw_ack_1 = 0;
    check("one_ready", 32'(draw_ready_1), 32'd1);

    // Single channel, MAX_TRIES=1, nibble C -> fallback symbol C-10 = 2
    seed_1 = 10'h00C; seed_load_1 = 1;
    tick();
    seed_load_1 = 0;
    draw_req_1 = 1;
    tick();
    draw_req_1 = 0;
    tick(); tick();
    check("fb_valid", 32'(draw_valid_1),    32'd1);
    check("fb_value", 32'(draw_value_1),    32'd2);
    check("fb_flag",  32'(draw_fallback_1), 32'd1);
    draw_ack_1 = 1;
    tick();
    draw_ack_1 = 0;
    check("fb_ready", 32'(draw_ready_1),    32'd1);
    check("fb_clear", 32'(draw_fallback_1), 32'd0);

    // Stalled draw (channel 2 nibble C, enable=0) then reset mid-draw
    seed = 10'h003; seed_load = 1;
    tick();
    seed_load = 0;
    check("stall_seed", 32'(lfsr_state), 32'({10'h00C, 10'h006, 10'h003}));
    draw_req = 1;
    tick();
    draw_req = 0;
    draw_ack = 1;
    vpulse = 0;
    repeat (20) begin
      tick();
      if (draw_valid) vpulse++;
    end
    draw_ack = 0;
    check("stall_novalid", 32'(vpulse),     32'd0);
    check("stall_hold",    32'(lfsr_state), 32'({10'h00C, 10'h006, 10'h003}));
    check("stall_busy",    32'(draw_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("abort_ready", 32'(draw_ready), 32'd1);
    check("abort_valid", 32'(draw_valid), 32'd0);
    check("abort_state", 32'(lfsr_state), 32'({10'h004, 10'h002, 10'h001}));
    check("abort_value", 32'(draw_value), 32'd0);
    vpulse = 0;
    tick(); tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      if (draw_valid) vpulse++;
    end
    check("abort_nopulse", 32'(vpulse),     32'd0);
    check("abort_idle",    32'(draw_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
